// File: rtl/home_inventory_evt_pkg.sv
// Shared definitions for the home inventory event engine.
// - Default parameter values for the engine and its event FIFO.
// - FIFO entry layout: {hit mask (MSBs), timestamp (LSBs)}.
// - Width of the saturating drop counter.
package home_inventory_evt_pkg;

    localparam int unsigned NCH_DEF   = 8;
    localparam int unsigned SW_DEF    = 32;
    localparam int unsigned TSW_DEF   = 32;
    localparam int unsigned CW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 16;

    localparam int unsigned DROP_W    = 16;

    // Timestamp occupies bits [TSW-1:0], the channel mask sits directly above it.
    localparam int unsigned ENTRY_TS_LSB = 0;

    function automatic int unsigned entry_width(input int unsigned nch, input int unsigned tsw);
        return nch + tsw;
    endfunction

endpackage

// File: rtl/home_inventory_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for event log entries.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears pointers/level)
//   push, push_data write request and entry
//   push_accepted   push taken this cycle (room, or a pop in the same cycle)
//   pop_ready       consumer takes the head when rd_valid
//   rd_valid        head entry valid; rd_data is the head entry
//   level           number of occupied entries
module home_inventory_evt_fifo
    import home_inventory_evt_pkg::*;
#(
    parameter int unsigned WIDTH = entry_width(NCH_DEF, TSW_DEF),
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   push_accepted,
    input  logic                   pop_ready,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign rd_valid      = (level != '0);
    assign rd_data       = mem[rd_ptr];
    assign pop           = rd_valid && pop_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_accepted = push && ((level < LW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_accepted) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_accepted && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_accepted) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/home_inventory_event_engine.sv
// Per-channel event detector with level or hysteresis (edge) detection, saturating
// event counters, per-channel timestamps/deltas and an event log FIFO.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   sample_valid, ts_now            sample strobe and its timestamp
//   sample_flat, thresh_hi/lo_flat  per-channel samples and thresholds (SW bits each)
//   evt_en, mode_edge               per-channel enable and edge-mode select
//   clr_stats                       clears counts, drop_count and overflow
//   evt_count_flat, last_delta_flat, last_ts_ch_flat, last_ts   per-channel/global stats
//   evt_rd_valid/ready/mask/ts, fifo_level                      event log read side
//   overflow, drop_count            sticky drop flag and saturating drop count
module home_inventory_event_engine
    import home_inventory_evt_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned SW    = SW_DEF,
    parameter int unsigned TSW   = TSW_DEF,
    parameter int unsigned CW    = CW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [TSW-1:0]         ts_now,
    input  logic [NCH*SW-1:0]      sample_flat,
    input  logic [NCH*SW-1:0]      thresh_hi_flat,
    input  logic [NCH*SW-1:0]      thresh_lo_flat,
    input  logic [NCH-1:0]         evt_en,
    input  logic [NCH-1:0]         mode_edge,
    input  logic                   clr_stats,
    output logic [NCH*CW-1:0]      evt_count_flat,
    output logic [NCH*TSW-1:0]     last_delta_flat,
    output logic [NCH*TSW-1:0]     last_ts_ch_flat,
    output logic [TSW-1:0]         last_ts,
    output logic                   evt_rd_valid,
    input  logic                   evt_rd_ready,
    output logic [NCH-1:0]         evt_rd_mask,
    output logic [TSW-1:0]         evt_rd_ts,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int unsigned EW = entry_width(NCH, TSW);

    logic [NCH-1:0] hit;
    logic           any_hit;
    logic           push_accepted;
    logic [EW-1:0]  rd_data;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SW-1:0]  smp, hi, lo;
        logic           armed_q, seen_q, rise_q, en_prev_q;
        logic [CW-1:0]  count_q;
        logic [TSW-1:0] ts_q, delta_q;
        logic           rise_now, apply, armed_eff, seen_eff;
        logic [TSW-1:0] ts_eff;

        assign smp = sample_flat[i*SW +: SW];
        assign hi  = thresh_hi_flat[i*SW +: SW];
        assign lo  = thresh_lo_flat[i*SW +: SW];

        // A pending enable rise resets the channel history just before this sample.
        assign rise_now  = evt_en[i] && !en_prev_q;
        assign apply     = sample_valid && evt_en[i] && (rise_q || rise_now);
        assign armed_eff = armed_q || apply;
        assign seen_eff  = seen_q && !apply;
        assign ts_eff    = apply ? '0 : ts_q;

        assign hit[i] = evt_en[i] && sample_valid && (smp >= hi) && (!mode_edge[i] || armed_eff);

        always_ff @(posedge clk) begin
            if (rst) begin
                armed_q   <= 1'b1;
                seen_q    <= 1'b0;
                rise_q    <= 1'b0;
                en_prev_q <= 1'b0;
                count_q   <= '0;
                ts_q      <= '0;
                delta_q   <= '0;
            end else begin
                en_prev_q <= evt_en[i];
                rise_q    <= !apply && (rise_q || rise_now);

                if (sample_valid && mode_edge[i] && hit[i]) begin
                    armed_q <= 1'b0;
                end else if (sample_valid && mode_edge[i] && (smp < lo)) begin
                    armed_q <= 1'b1;
                end else begin
                    armed_q <= armed_eff;
                end

                seen_q <= seen_eff || hit[i];

                if (hit[i]) begin
                    ts_q    <= ts_now;
                    delta_q <= seen_eff ? (ts_now - ts_eff) : '0;
                end else if (apply) begin
                    ts_q    <= '0;
                    delta_q <= '0;
                end

                if (clr_stats) begin
                    count_q <= '0;
                end else if (hit[i] && (count_q != '1)) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end

        assign evt_count_flat[i*CW +: CW]    = count_q;
        assign last_delta_flat[i*TSW +: TSW] = delta_q;
        assign last_ts_ch_flat[i*TSW +: TSW] = ts_q;
    end

    assign any_hit = |hit;

    home_inventory_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (any_hit),
        .push_data     ({hit, ts_now}),
        .push_accepted (push_accepted),
        .pop_ready     (evt_rd_ready),
        .rd_valid      (evt_rd_valid),
        .rd_data       (rd_data),
        .level         (fifo_level)
    );

    assign evt_rd_mask = rd_data[TSW +: NCH];
    assign evt_rd_ts   = rd_data[ENTRY_TS_LSB +: TSW];

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ts    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (any_hit) begin
                last_ts <= ts_now;
            end
            // Clear wins over a drop in the same cycle.
            if (clr_stats) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (any_hit && !push_accepted) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule
